// File: rtl/cpu_ctrl.sv
// Two-operand ALU sequencer: clears the operand memory, fetches two operands
// with one LOAD each, executes the latched op and pulses done.
module cpu_ctrl #(
    parameter logic [3:0] CLEAR = 4'd0,
    parameter logic [3:0] LOAD  = 4'd1,
    parameter logic [3:0] HOLD  = 4'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [3:0] entrada,
    output logic [3:0] tx,
    output logic [3:0] reg_a,
    output logic [3:0] reg_b,
    output logic [4:0] resultado,
    output logic       busy,
    output logic       done,
    output logic [3:0] current_state
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        CLR  = 4'd1,
        LDA  = 4'd2,
        WA   = 4'd3,
        LDB  = 4'd4,
        WB   = 4'd5,
        EXEC = 4'd6,
        FIN  = 4'd7
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] op_reg;
    logic [3:0] tx_reg, tx_next;
    logic [3:0] reg_a_reg, reg_b_reg;
    logic [4:0] res_reg, alu_next;
    logic       busy_reg, done_reg;
    logic [3:0] and_bits, or_bits;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_logic_bits
            assign and_bits[gi] = reg_a_reg[gi] & reg_b_reg[gi];
            assign or_bits[gi]  = reg_a_reg[gi] | reg_b_reg[gi];
        end
    endgenerate

    // Subtraction wraps mod 32, so bit 4 reads as the borrow.
    always_comb begin
        alu_next = 5'd0;
        case (op_reg)
            2'b00:   alu_next = {1'b0, reg_a_reg} + {1'b0, reg_b_reg};
            2'b01:   alu_next = {1'b0, reg_a_reg} - {1'b0, reg_b_reg};
            2'b10:   alu_next = {1'b0, and_bits};
            default: alu_next = {1'b0, or_bits};
        endcase
    end

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = start ? CLR : IDLE;
            CLR:     state_next = LDA;
            LDA:     state_next = WA;
            WA:      state_next = LDB;
            LDB:     state_next = WB;
            WB:      state_next = EXEC;
            EXEC:    state_next = FIN;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        tx_next = HOLD;
        case (state_next)
            CLR:      tx_next = CLEAR;
            LDA, LDB: tx_next = LOAD;
            default:  tx_next = HOLD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= 2'b00;
            tx_reg    <= HOLD;
            reg_a_reg <= 4'd0;
            reg_b_reg <= 4'd0;
            res_reg   <= 5'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            tx_reg    <= tx_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_next == FIN);
            case (state_reg)
                IDLE: if (start) op_reg <= op;
                CLR: begin
                    reg_a_reg <= 4'd0;
                    reg_b_reg <= 4'd0;
                    res_reg   <= 5'd0;
                end
                WA:      reg_a_reg <= entrada;
                WB:      reg_b_reg <= entrada;
                EXEC:    res_reg   <= alu_next;
                default: ;
            endcase
        end
    end

    assign tx            = tx_reg;
    assign reg_a         = reg_a_reg;
    assign reg_b         = reg_b_reg;
    assign resultado     = res_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign current_state = state_reg;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: operand-memory model, cycle-level
// behavioural reference, directed scenarios and a randomized run.
module tb_cpu_ctrl;

    localparam logic [3:0] CLEAR = 4'd0;
    localparam logic [3:0] LOAD  = 4'd1;
    localparam logic [3:0] HOLD  = 4'd2;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [3:0] entrada;
    logic [3:0] tx, reg_a, reg_b, current_state;
    logic [4:0] resultado;
    logic       busy, done;

    cpu_ctrl #(.CLEAR(CLEAR), .LOAD(LOAD), .HOLD(HOLD)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .entrada(entrada),
        .tx(tx), .reg_a(reg_a), .reg_b(reg_b), .resultado(resultado),
        .busy(busy), .done(done), .current_state(current_state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: cycles elapsed since the operation was accepted (0 = idle).
    int m_phase, m_op, m_a, m_b, m_r;

    // Operand memory: returns mem_seq[0], mem_seq[1], ... one cycle after each LOAD.
    int   mem_seq[2];
    int   mem_idx;
    bit   mem_rand;
    logic prev_load, prev_done;
    int   tx_log[$];
    int   done_cnt, load_cnt;

    function automatic int alu(input int o, input int a, input int b);
        case (o)
            0:       return a + b;
            1:       return (a - b + 32) % 32;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge: compare, drive inputs, advance model.
    task automatic step(input logic rst, input logic st, input logic [1:0] o);
        int e_tx;
        e_tx = (m_phase == 1) ? 0 : ((m_phase == 2 || m_phase == 4) ? 1 : 2);
        check("tx", int'(tx), e_tx);
        check("state", int'(current_state), m_phase);
        check("busy", int'(busy), int'(m_phase != 0));
        check("done", int'(done), int'(m_phase == 7));
        check("reg_a", int'(reg_a), m_a);
        check("reg_b", int'(reg_b), m_b);
        check("resultado", int'(resultado), m_r);
        check("busy_matches_state", int'(busy), int'(current_state != 4'd0));
        check("done_single_pulse", int'(done && prev_done), 0);
        prev_done = done;
        tx_log.push_back(int'(tx));
        if (tx == LOAD) load_cnt++;
        if (done) done_cnt++;

        if (prev_load) begin
            if (mem_rand) mem_seq[mem_idx] = int'($urandom_range(0, 15));
            entrada = 4'(mem_seq[mem_idx]);
            mem_idx = 1 - mem_idx;
        end else begin
            entrada = 4'($urandom_range(0, 15));
        end
        prev_load = (tx == LOAD);

        reset = rst;
        start = st;
        op    = o;

        if (rst) begin
            m_phase = 0; m_op = 0; m_a = 0; m_b = 0; m_r = 0;
        end else begin
            if (m_phase == 0 && st) m_op = int'(o);
            if (m_phase == 1) begin m_a = 0; m_b = 0; m_r = 0; end
            if (m_phase == 3) m_a = int'(entrada);
            if (m_phase == 5) m_b = int'(entrada);
            if (m_phase == 6) m_r = alu(m_op, m_a, m_b);
            m_phase = (m_phase == 0) ? (st ? 1 : 0) : (m_phase + 1) % 8;
        end
        @(negedge clock);
    endtask

    task automatic begin_op(input int first, input int second);
        mem_seq[0] = first;
        mem_seq[1] = second;
        mem_idx    = 0;
        mem_rand   = 1'b0;
        tx_log.delete();
        done_cnt = 0;
        load_cnt = 0;
    endtask

    task automatic run_op(input logic [1:0] o, input int first, input int second,
                          input int exp_res, input string name);
        begin_op(first, second);
        step(1'b0, 1'b1, o);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 2'($urandom_range(0, 3)));
        check({name, "_resultado"}, int'(resultado), exp_res);
        check({name, "_loads"}, load_cnt, 2);
        check({name, "_done_count"}, done_cnt, 1);
    endtask

    int exp_tx[8] = '{2, 0, 1, 2, 1, 2, 2, 2};

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; entrada = 4'd0;
        m_phase = 0; m_op = 0; m_a = 0; m_b = 0; m_r = 0;
        mem_seq[0] = 5; mem_seq[1] = 3; mem_idx = 0; mem_rand = 1'b0;
        prev_load = 1'b0; prev_done = 1'b0;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst_tx", int'(tx), 2);
        check("rst_state", int'(current_state), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_resultado", int'(resultado), 0);
        step(1'b0, 1'b0, 2'b00);

        // Add, with the full tx sequence pinned
        run_op(2'b00, 5, 3, 8, "add");
        check("add_reg_a", int'(reg_a), 5);
        check("add_reg_b", int'(reg_b), 3);
        check("add_txlog_len", tx_log.size(), 8);
        for (int i = 0; i < 8 && i < tx_log.size(); i++)
            check($sformatf("add_tx%0d", i), tx_log[i], exp_tx[i]);

        run_op(2'b01, 5, 3, 2, "sub");
        run_op(2'b10, 5, 3, 1, "and");
        run_op(2'b11, 5, 3, 7, "or");
        run_op(2'b01, 3, 5, 5'b11110, "sub_borrow");
        check("hold_after_fin", int'(resultado), 5'b11110);
        step(1'b0, 1'b0, 2'b00);
        check("hold_idle", int'(resultado), 5'b11110);

        // Start with op=11 during LDB is ignored; latched add is used
        begin_op(5, 3);
        step(1'b0, 1'b1, 2'b00);
        repeat (3) step(1'b0, 1'b0, 2'b00);
        check("busy_in_ldb", int'(current_state), 4);
        step(1'b0, 1'b1, 2'b11);
        repeat (3) step(1'b0, 1'b0, 2'b11);
        check("busy_ignore_resultado", int'(resultado), 8);
        check("busy_ignore_done", done_cnt, 1);
        step(1'b0, 1'b0, 2'b00);
        check("busy_ignore_back_idle", int'(current_state), 0);

        // Reset asserted in WA aborts the operation
        begin_op(5, 3);
        step(1'b0, 1'b1, 2'b00);
        repeat (2) step(1'b0, 1'b0, 2'b00);
        check("abort_in_wa", int'(current_state), 3);
        step(1'b1, 1'b0, 2'b00);
        check("abort_state", int'(current_state), 0);
        check("abort_tx", int'(tx), 2);
        check("abort_reg_a", int'(reg_a), 0);
        check("abort_busy", int'(busy), 0);
        repeat (10) step(1'b0, 1'b0, 2'b00);
        check("abort_no_done", done_cnt, 0);

        // Start held high: back-to-back operations with one idle cycle between
        begin_op(5, 3);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 2'b00);
        check("b2b_done_count", done_cnt, 2);
        check("b2b_loads", load_cnt, 4);
        step(1'b0, 1'b0, 2'b00);

        // Randomized run, operand values random, occasional reset
        mem_rand = 1'b1;
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
                 2'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
